// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet burst generator.
// On a start request, emits num_pkts packets of pkt_len beats each. Beat data
// counts up from the latched seed across the whole burst. An optional fixed idle gap
// separates packets, and a one-cycle done pulse marks the end of the burst.
// Every output comes straight from a flop.
module axis_pkt_gen #(
    parameter int DW  = 8,
    parameter int LW  = 8,
    parameter int GAP = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] pkt_len,
    input  logic [LW-1:0] num_pkts,
    input  logic [DW-1:0] seed,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    output logic          m_tlast,
    input  logic          m_tready,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    // Last value of the gap counter before leaving S_GAP. It is unused when GAP == 0.
    localparam logic [7:0] GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;       // latched beats per packet
    logic [LW-1:0] npk_q, npk_d;       // latched packets per burst
    logic [DW-1:0] seed_q, seed_d;     // latched first data value
    logic [LW-1:0] beat_q, beat_d;     // 1-based index of the beat on the bus
    logic [LW-1:0] pkt_q, pkt_d;       // 1-based index of the current packet
    logic [7:0]    gap_q, gap_d;       // idle cycles already spent in S_GAP
    logic [DW-1:0] tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [LW-1:0] beat_nxt;
    logic [DW-1:0] data_nxt;
    logic          xfer;

    assign beat_nxt = beat_q + 1'b1;
    assign data_nxt = tdata_q + 1'b1;
    assign xfer     = tvalid_q && m_tready;

    // Next-state and next-output logic for the burst sequencer.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        npk_d    = npk_q;
        seed_d   = seed_q;
        beat_d   = beat_q;
        pkt_d    = pkt_q;
        gap_d    = gap_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                // Requests for a zero-length packet or zero packets are dropped.
                if (start && (pkt_len != '0) && (num_pkts != '0)) begin
                    len_d   = pkt_len;
                    npk_d   = num_pkts;
                    seed_d  = seed;
                    state_d = S_SEND;
                end
            end

            S_SEND: begin
                if (!tvalid_q) begin
                    // Only reached on the first cycle of a burst: present the
                    // seed beat. Later first beats are presented directly from
                    // the previous packet's last transfer or from the gap.
                    tvalid_d = 1'b1;
                    tdata_d  = seed_q;
                    beat_d   = LW'(1);
                    pkt_d    = LW'(1);
                    tlast_d  = (len_q == LW'(1));
                end else if (xfer) begin
                    if (tlast_q) begin
                        if (pkt_q == npk_q) begin
                            state_d  = S_DONE;
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                            done_d   = 1'b1;
                        end else begin
                            pkt_d = pkt_q + 1'b1;
                            if (GAP > 0) begin
                                state_d  = S_GAP;
                                gap_d    = 8'd0;
                                tvalid_d = 1'b0;
                                tlast_d  = 1'b0;
                            end else begin
                                // Back-to-back packets: next first beat with no bubble.
                                tdata_d = data_nxt;
                                beat_d  = LW'(1);
                                tlast_d = (len_q == LW'(1));
                            end
                        end
                    end else begin
                        tdata_d = data_nxt;
                        beat_d  = beat_nxt;
                        tlast_d = (beat_nxt == len_q);
                    end
                end
                // While stalled (valid && !ready), everything holds by default.
            end

            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    // Leave the gap with the beat already on the bus, so the
                    // idle time is exactly GAP cycles.
                    state_d  = S_SEND;
                    tvalid_d = 1'b1;
                    tdata_d  = data_nxt;
                    beat_d   = LW'(1);
                    tlast_d  = (len_q == LW'(1));
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end

            S_DONE: begin
                state_d  = S_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end

            default: begin
                state_d  = S_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers. Reset aborts any burst immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            npk_q    <= '0;
            seed_q   <= '0;
            beat_q   <= '0;
            pkt_q    <= '0;
            gap_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            npk_q    <= npk_d;
            seed_q   <= seed_d;
            beat_q   <= beat_d;
            pkt_q    <= pkt_d;
            gap_q    <= gap_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign m_tdata  = tdata_q;
    assign m_tvalid = tvalid_q;
    assign m_tlast  = tlast_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed-vector bench for axis_pkt_gen. Each table row is one clock cycle: the
// row's inputs are driven, and the outputs are then checked 1 time unit after the
// rising edge. Two instances are used: one with GAP=0 and one with GAP=2.
module tb_axis_pkt_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, tready;
    logic [7:0] pkt_len, num_pkts, seed;
    logic       sel_b;

    logic       start_a, start_b;
    logic [7:0] a_data, b_data;
    logic       a_valid, a_last, a_busy, a_done;
    logic       b_valid, b_last, b_busy, b_done;

    assign start_a = start & ~sel_b;
    assign start_b = start & sel_b;

    always #5 clk = ~clk;

    axis_pkt_gen #(.DW(8), .LW(8), .GAP(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .pkt_len(pkt_len),
        .num_pkts(num_pkts), .seed(seed), .m_tdata(a_data), .m_tvalid(a_valid),
        .m_tlast(a_last), .m_tready(tready), .busy(a_busy), .done(a_done)
    );

    axis_pkt_gen #(.DW(8), .LW(8), .GAP(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .pkt_len(pkt_len),
        .num_pkts(num_pkts), .seed(seed), .m_tdata(b_data), .m_tvalid(b_valid),
        .m_tlast(b_last), .m_tready(tready), .busy(b_busy), .done(b_done)
    );

    typedef struct {
        string      name;
        logic       which;
        logic       st;
        logic [7:0] len, npk, sd;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic       el, eb, edn;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Scenario configuration used by row()
    string      c_name;
    logic       c_which;
    logic [7:0] c_len, c_npk, c_sd;

    function automatic void cfg(string nm, logic w, logic [7:0] l, logic [7:0] n, logic [7:0] s);
        c_name = nm; c_which = w; c_len = l; c_npk = n; c_sd = s;
    endfunction

    function automatic void row(logic st, logic rdy, logic ev, logic [7:0] ed,
                                logic el, logic eb, logic edn);
        vec_t v;
        v.name = c_name; v.which = c_which; v.st = st;
        v.len = c_len; v.npk = c_npk; v.sd = c_sd; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.el = el; v.eb = eb; v.edn = edn;
        vq.push_back(v);
    endfunction

    // Compares one output snapshot; data is only checked while valid is expected.
    task automatic check(string nm, int idx, logic w, logic ev, logic [7:0] ed,
                         logic el, logic eb, logic edn);
        logic       v, l, b, dn;
        logic [7:0] d;
        if (w) begin v = b_valid; d = b_data; l = b_last; b = b_busy; dn = b_done; end
        else   begin v = a_valid; d = a_data; l = a_last; b = a_busy; dn = a_done; end
        n_vec++;
        if (v !== ev || l !== el || b !== eb || dn !== edn || (ev && d !== ed)) begin
            n_bad++;
            $display("FAIL %s[%0d]: got valid=%b data=%h last=%b busy=%b done=%b, want valid=%b data=%h last=%b busy=%b done=%b",
                     nm, idx, v, d, l, b, dn, ev, ed, el, eb, edn);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tready = 1'b1; sel_b = 1'b0;
        pkt_len = 8'd0; num_pkts = 8'd0; seed = 8'd0;

        // ---- vector table -------------------------------------------------
        // 4 beats from 0x10 with ready held high; done follows the last beat
        cfg("basic", 1'b0, 8'd4, 8'd1, 8'h10);
        row(1, 1, 0, 8'h00, 0, 1, 0);
        row(0, 1, 1, 8'h10, 0, 1, 0);
        row(0, 1, 1, 8'h11, 0, 1, 0);
        row(0, 1, 1, 8'h12, 0, 1, 0);
        row(0, 1, 1, 8'h13, 1, 1, 0);
        row(0, 1, 0, 8'h00, 0, 1, 1);
        row(0, 1, 0, 8'h00, 0, 0, 0);
        // Same burst with ready toggling: every stall must hold data/last
        cfg("stall", 1'b0, 8'd4, 8'd1, 8'h10);
        row(1, 0, 0, 8'h00, 0, 1, 0);
        row(0, 0, 1, 8'h10, 0, 1, 0);
        row(0, 1, 1, 8'h11, 0, 1, 0);
        row(0, 0, 1, 8'h11, 0, 1, 0);
        row(0, 1, 1, 8'h12, 0, 1, 0);
        row(0, 0, 1, 8'h12, 0, 1, 0);
        row(0, 1, 1, 8'h13, 1, 1, 0);
        row(0, 0, 1, 8'h13, 1, 1, 0);
        row(0, 1, 0, 8'h00, 0, 1, 1);
        row(0, 0, 0, 8'h00, 0, 0, 0);
        // Data wraps from 0xFF to 0x00
        cfg("wrap", 1'b0, 8'd4, 8'd1, 8'hFE);
        row(1, 1, 0, 8'h00, 0, 1, 0);
        row(0, 1, 1, 8'hFE, 0, 1, 0);
        row(0, 1, 1, 8'hFF, 0, 1, 0);
        row(0, 1, 1, 8'h00, 0, 1, 0);
        row(0, 1, 1, 8'h01, 1, 1, 0);
        row(0, 1, 0, 8'h00, 0, 1, 1);
        row(0, 1, 0, 8'h00, 0, 0, 0);
        // Start requests for zero beats or zero packets are ignored
        cfg("len0", 1'b0, 8'd0, 8'd1, 8'h55);
        row(1, 1, 0, 8'h00, 0, 0, 0);
        row(0, 1, 0, 8'h00, 0, 0, 0);
        cfg("npk0", 1'b0, 8'd3, 8'd0, 8'h55);
        row(1, 1, 0, 8'h00, 0, 0, 0);
        row(0, 1, 0, 8'h00, 0, 0, 0);
        // 2 packets of 2 beats, back to back; a second start with new
        // parameters mid-burst must change nothing
        cfg("busy_start", 1'b0, 8'd2, 8'd2, 8'h20);
        row(1, 1, 0, 8'h00, 0, 1, 0);
        row(0, 1, 1, 8'h20, 0, 1, 0);
        cfg("busy_start", 1'b0, 8'd5, 8'd7, 8'h99);
        row(1, 1, 1, 8'h21, 1, 1, 0);
        row(1, 1, 1, 8'h22, 0, 1, 0);
        row(0, 0, 1, 8'h22, 0, 1, 0);
        row(0, 1, 1, 8'h23, 1, 1, 0);
        row(0, 1, 0, 8'h00, 0, 1, 1);
        row(0, 1, 0, 8'h00, 0, 0, 0);
        // pkt_len=1 with GAP=0: every beat has last, and there is no bubble
        cfg("len1_nogap", 1'b0, 8'd1, 8'd2, 8'h05);
        row(1, 1, 0, 8'h00, 0, 1, 0);
        row(0, 1, 1, 8'h05, 1, 1, 0);
        row(0, 1, 1, 8'h06, 1, 1, 0);
        row(0, 1, 0, 8'h00, 0, 1, 1);
        row(0, 1, 0, 8'h00, 0, 0, 0);
        // GAP=2 instance: three single-beat packets, exactly 2 idle cycles between
        cfg("gap2", 1'b1, 8'd1, 8'd3, 8'h00);
        row(1, 1, 0, 8'h00, 0, 1, 0);
        row(0, 1, 1, 8'h00, 1, 1, 0);
        row(0, 1, 0, 8'h00, 0, 1, 0);
        row(0, 1, 0, 8'h00, 0, 1, 0);
        row(0, 1, 1, 8'h01, 1, 1, 0);
        row(0, 1, 0, 8'h00, 0, 1, 0);
        row(0, 1, 0, 8'h00, 0, 1, 0);
        row(0, 1, 1, 8'h02, 1, 1, 0);
        row(0, 1, 0, 8'h00, 0, 1, 1);
        row(0, 1, 0, 8'h00, 0, 0, 0);

        // ---- reset state, checked without any clock edge -----------------
        #3;
        check("reset_a", 0, 1'b0, 0, 8'h00, 0, 0, 0);
        check("reset_b", 0, 1'b1, 0, 8'h00, 0, 0, 0);
        if (a_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_data: got %h, want 00", a_data);
        end
        n_vec++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // ---- apply the table ---------------------------------------------
        for (int i = 0; i < vq.size(); i++) begin
            sel_b    = vq[i].which;
            start    = vq[i].st;
            pkt_len  = vq[i].len;
            num_pkts = vq[i].npk;
            seed     = vq[i].sd;
            tready   = vq[i].rdy;
            @(posedge clk); #1;
            check(vq[i].name, i, vq[i].which, vq[i].ev, vq[i].ed, vq[i].el, vq[i].eb, vq[i].edn);
        end
        start = 1'b0;

        // ---- reset during the 2nd beat of a 4-beat packet -----------------
        sel_b = 1'b0; tready = 1'b1;
        pkt_len = 8'd4; num_pkts = 8'd1; seed = 8'h30;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("abort_beat1", 0, 1'b0, 1, 8'h30, 0, 1, 0);
        @(posedge clk); #1;
        check("abort_beat2", 0, 1'b0, 1, 8'h31, 0, 1, 0);
        #2 rst = 1'b1;
        #1;
        check("abort_async", 0, 1'b0, 0, 8'h00, 0, 0, 0);
        n_vec++;
        if (a_data !== 8'h00) begin
            n_bad++;
            $display("FAIL abort_data: got %h, want 00", a_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check("abort_quiet", k, 1'b0, 0, 8'h00, 0, 0, 0);
        end
        // A new start after the abort begins again from its own seed
        seed = 8'h40; pkt_len = 8'd1; num_pkts = 8'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("restart", 0, 1'b0, 1, 8'h40, 1, 1, 0);
        @(posedge clk); #1;
        check("restart_done", 0, 1'b0, 0, 8'h00, 0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_pkt_gen.md
AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

Interface
REQ-001 SHALL have parameter DW, default 8: width of m_tdata and seed.
REQ-002 SHALL have parameter LW, default 8: width of pkt_len and num_pkts.
REQ-003 SHALL have parameter GAP, default 0: idle cycles between packets, range 0..255.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: single-cycle request to begin a burst of packets.
REQ-007 SHALL have port pkt_len, input, LW bits: beats per packet.
REQ-008 SHALL have port num_pkts, input, LW bits: packets per burst.
REQ-009 SHALL have port seed, input, DW bits: data value of the first beat of the burst.
REQ-010 SHALL have port m_tdata, output, DW bits: AXI-Stream data.
REQ-011 SHALL have port m_tvalid, output, 1 bit: AXI-Stream valid.
REQ-012 SHALL have port m_tlast, output, 1 bit: AXI-Stream last; marks the final beat of each packet.
REQ-013 SHALL have port m_tready, input, 1 bit: AXI-Stream ready from the sink.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 SHALL have port done, output, 1 bit: single-cycle pulse when the burst completes.

Function
REQ-016 SHALL implement the states IDLE, SEND, GAP and DONE; every output SHALL be driven from a register.
REQ-017 In IDLE, start=1 with pkt_len!=0 and num_pkts!=0 SHALL latch pkt_len, num_pkts and seed and move to SEND.
- Given start sampled at edge N, m_tvalid SHALL be 1 after edge N+1.
REQ-018 In IDLE, start with pkt_len=0 or num_pkts=0 SHALL be ignored: the block stays in IDLE and no done pulse is produced.
REQ-019 While the state is not IDLE, start SHALL be ignored; changes to pkt_len, num_pkts or seed SHALL NOT affect the burst in progress.
REQ-020 A beat SHALL transfer only on a cycle where m_tvalid=1 and m_tready=1.
REQ-021 While m_tvalid=1 and m_tready=0, m_tdata, m_tlast and m_tvalid SHALL hold their values unchanged.
REQ-022 m_tvalid SHALL NOT depend on m_tready.
REQ-023 Beat data SHALL begin at the latched seed and increment by 1 on each transferred beat, modulo 2^DW.
- The sequence SHALL continue across packet boundaries within a burst.
REQ-024 m_tlast SHALL be 1 exactly on beat pkt_len of each packet; when pkt_len=1, every beat SHALL carry m_tlast=1.
REQ-025 A transfer with m_tlast=1 when more packets remain SHALL move to GAP if GAP>0; if GAP=0, the next packet's first beat SHALL be presented with m_tvalid held at 1 and no bubble.
REQ-026 In GAP, m_tvalid SHALL be 0 for exactly GAP cycles, after which the state SHALL return to SEND.
REQ-027 The transfer with m_tlast=1 of the final packet SHALL move to DONE.
- In DONE, m_tvalid=0, done=1 and busy=1 SHALL hold for one cycle, then the state SHALL return to IDLE.
REQ-028 The beat counter and packet counter SHALL be LW bits wide and SHALL support pkt_len and num_pkts up to 2^LW-1 with no overflow.

Reset
REQ-029 While rst=1, the block SHALL be in IDLE with m_tvalid=0, m_tlast=0, m_tdata=0, busy=0 and done=0, with no clock edge required.
REQ-030 Reset asserted mid-packet SHALL abort the burst with no further beats.
- After reset is released, the block SHALL remain idle until a new valid start.

Verification
REQ-031 seed=0x10, pkt_len=4, num_pkts=1, m_tready=1 -> beats 0x10, 0x11, 0x12, 0x13; m_tlast on 0x13 only; done pulses one cycle later.
REQ-032 Same configuration with m_tready toggling 1010... -> the same four values in order, with data and last stable during stalls and no beat lost or duplicated.
REQ-033 pkt_len=1, num_pkts=3, GAP=2, seed=0 -> beats 0x00, 0x01, 0x02, each with m_tlast=1, and m_tvalid=0 for exactly 2 cycles between them.
REQ-034 seed=0xFE, pkt_len=4, num_pkts=1 -> beats 0xFE, 0xFF, 0x00, 0x01 (wrap-around).
REQ-035 rst pulsed during the 2nd beat of a 4-beat packet -> m_tvalid=0 and busy=0 immediately; no beats and no done until the next start.
REQ-036 start with pkt_len=0, then a second start while busy -> both starts ignored: no beats for the first, and the running burst is unaffected by the second.
